// File: rtl/decode_stage_if.sv
// Fetch, writeback, flush and execute-side signals of the decode stage.
// The slave modport is the stage itself; the master modport is its environment.
interface decode_stage_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned REG_SEL_BITS = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] PC;
    logic [31:0]             instruction;
    logic                    write;
    logic [REG_SEL_BITS-1:0] write_reg;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_PC;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [REG_SEL_BITS-1:0] rd;
    logic                    rd_write;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [DATA_WIDTH-1:0]   extend_imm;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic [ADDRESS_BITS-1:0] JAL_target;

    modport master (
        output in_valid, PC, instruction, write, write_reg, write_data, flush, out_ready,
        input  in_ready, out_valid, out_PC, rs1_data, rs2_data, rd, rd_write, opcode, funct3,
               funct7, extend_imm, branch_target, JAL_target
    );

    modport slave (
        input  in_valid, PC, instruction, write, write_reg, write_data, flush, out_ready,
        output in_ready, out_valid, out_PC, rs1_data, rs2_data, rd, rd_write, opcode, funct3,
               funct7, extend_imm, branch_target, JAL_target
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage: regfile read, immediate/target formation, busy-bit hazard scoreboard.
// Define WRITE_BYPASS_EN to forward same-cycle writeback data into an otherwise stalled operand.
module decode_stage #(
    parameter int unsigned CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned REG_SEL_BITS = 5
) (
    input logic           clock,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REG_SEL_BITS;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || ADDRESS_BITS > 32 || REG_SEL_BITS > 5)
    begin : g_param_check
        $error("decode_stage core %0d: unsupported parameterisation", CORE);
    end

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [DATA_WIDTH-1:0]   rs1_data;
        logic [DATA_WIDTH-1:0]   rs2_data;
        logic [REG_SEL_BITS-1:0] rd;
        logic                    rd_write;
        logic [6:0]              opcode;
        logic [2:0]              funct3;
        logic [6:0]              funct7;
        logic [DATA_WIDTH-1:0]   imm;
        logic [ADDRESS_BITS-1:0] branch_target;
        logic [ADDRESS_BITS-1:0] jal_target;
    } entry_t;

    logic                  valid_q, valid_d;
    entry_t                entry_q, entry_d, dec_entry;
    logic [NumRegs-1:0]    busy_q, busy_d;
    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];

    logic [6:0]              opc;
    logic [REG_SEL_BITS-1:0] rs1_sel, rs2_sel, rd_sel;
    logic                    use1, use2, dec_rd_write;
    logic                    wb_en, fwd1, fwd2, hazard, in_ready, accept;
    logic [31:0]             imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;

    // Field decode, hazard detection and handshake.
    always_comb begin
        opc          = bus.instruction[6:0];
        rs1_sel      = bus.instruction[15 +: REG_SEL_BITS];
        rs2_sel      = bus.instruction[20 +: REG_SEL_BITS];
        rd_sel       = bus.instruction[7 +: REG_SEL_BITS];
        use1         = !(opc == OpLui || opc == OpAuipc || opc == OpJal);
        use2         = (opc == OpBranch) || (opc == OpStore) || (opc == OpOp);
        dec_rd_write = (rd_sel != '0) && !(opc == OpBranch || opc == OpStore);
        wb_en        = bus.write && (bus.write_reg != '0);
`ifdef WRITE_BYPASS_EN
        fwd1         = wb_en && (bus.write_reg == rs1_sel);
        fwd2         = wb_en && (bus.write_reg == rs2_sel);
`else
        fwd1         = 1'b0;
        fwd2         = 1'b0;
`endif
        // The WAW term is never bypassed: the pending writer must retire first.
        hazard       = (use1 && busy_q[rs1_sel] && !fwd1) ||
                       (use2 && busy_q[rs2_sel] && !fwd2) ||
                       (dec_rd_write && busy_q[rd_sel]);
        in_ready     = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
        accept       = bus.in_valid && in_ready;
    end

    always_comb begin
        imm_i = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
        imm_s = {{20{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]};
        imm_b = {{19{bus.instruction[31]}}, bus.instruction[31], bus.instruction[7],
                 bus.instruction[30:25], bus.instruction[11:8], 1'b0};
        imm_u = {bus.instruction[31:12], 12'b0};
        imm_j = {{11{bus.instruction[31]}}, bus.instruction[31], bus.instruction[19:12],
                 bus.instruction[20], bus.instruction[30:21], 1'b0};
        case (opc)
            OpLui, OpAuipc: imm_sel = imm_u;
            OpJal:          imm_sel = imm_j;
            OpBranch:       imm_sel = imm_b;
            OpStore:        imm_sel = imm_s;
            default:        imm_sel = imm_i;
        endcase

        dec_entry.pc            = bus.PC;
        dec_entry.rs1_data      = fwd1 ? bus.write_data : regs_q[rs1_sel];
        dec_entry.rs2_data      = fwd2 ? bus.write_data : regs_q[rs2_sel];
        dec_entry.rd            = rd_sel;
        dec_entry.rd_write      = dec_rd_write;
        dec_entry.opcode        = opc;
        dec_entry.funct3        = bus.instruction[14:12];
        dec_entry.funct7        = bus.instruction[31:25];
        dec_entry.imm           = DATA_WIDTH'($signed(imm_sel));
        dec_entry.branch_target = bus.PC + imm_b[ADDRESS_BITS-1:0];
        dec_entry.jal_target    = bus.PC + imm_j[ADDRESS_BITS-1:0];
    end

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        busy_d  = busy_q;
        regs_d  = regs_q;
        if (accept) begin
            valid_d = 1'b1;
            entry_d = dec_entry;
        end else if (bus.flush || bus.out_ready) begin
            valid_d = 1'b0;
        end
        if (wb_en) begin
            regs_d[bus.write_reg] = bus.write_data;
            busy_d[bus.write_reg] = 1'b0;
        end
        // A flushed writer will never retire, so release its destination here.
        if (bus.flush && valid_q && entry_q.rd_write) begin
            busy_d[entry_q.rd] = 1'b0;
        end
        if (accept && dec_rd_write) begin
            busy_d[rd_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
            busy_q  <= '0;
            regs_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_PC        = entry_q.pc;
    assign bus.rs1_data      = entry_q.rs1_data;
    assign bus.rs2_data      = entry_q.rs2_data;
    assign bus.rd            = entry_q.rd;
    assign bus.rd_write      = entry_q.rd_write;
    assign bus.opcode        = entry_q.opcode;
    assign bus.funct3        = entry_q.funct3;
    assign bus.funct7        = entry_q.funct7;
    assign bus.extend_imm    = entry_q.imm;
    assign bus.branch_target = entry_q.branch_target;
    assign bus.JAL_target    = entry_q.jal_target;
endmodule

// File: tb/tb_decode_stage.sv
// Scenario bench for decode_stage: expected entries are queued at accept and checked at output.
module tb_decode_stage;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpOp   = 7'b0110011;
    localparam logic [6:0] OpLoad = 7'b0000011;

    typedef struct {
        logic [19:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rdw;
        logic [31:0] imm;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mregs [32];
    logic [31:0] instr;

    decode_stage_if bus ();

    decode_stage dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                          logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OpOp};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        bus.write = 1'b1; bus.write_reg = r; bus.write_data = d;
        mregs[r] = d;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic offer(input logic [19:0] pc, input logic [31:0] ins);
        bus.in_valid = 1'b1; bus.PC = pc; bus.instruction = ins;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_addi();
        writeback(5'd5, 32'h1234);
        instr = enc_i(OpImm, 5'd6, 3'd0, 5'd5, 12'hFFF);
        offer(20'h00100, instr);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL addi_accept: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00100, rs1: 32'h1234, rs2: 32'h0, rd: 5'd6, rdw: 1'b1,
                       imm: 32'hFFFF_FFFF});
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_PC !== e.pc || bus.rs1_data !== e.rs1 ||
            bus.extend_imm !== e.imm || bus.rd !== e.rd || bus.rd_write !== e.rdw) begin
            miscompares++;
            $display("FAIL addi_entry: got v=%b pc=%h rs1=%h imm=%h rd=%0d rdw=%b want v=1 pc=%h rs1=%h imm=%h rd=%0d rdw=%b",
                     bus.out_valid, bus.out_PC, bus.rs1_data, bus.extend_imm, bus.rd,
                     bus.rd_write, e.pc, e.rs1, e.imm, e.rd, e.rdw);
        end
        tick();
    endtask

    task automatic test_raw_hazard();
        instr = enc_r(7'd0, 5'd6, 5'd6, 3'd0, 5'd7);
        offer(20'h00104, instr);
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++; $display("FAIL raw_stall: in_ready got %b want 0", bus.in_ready);
            end
            tick();
        end
        bus.write = 1'b1; bus.write_reg = 5'd6; bus.write_data = 32'h5555; mregs[6] = 32'h5555;
        @(negedge clk);
`ifdef WRITE_BYPASS_EN
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL raw_bypass: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00104, rs1: mregs[6], rs2: mregs[6], rd: 5'd7, rdw: 1'b1,
                       imm: 32'h0});
        tick();
        bus.write = 1'b0;
`else
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL raw_wb_cycle: in_ready got %b want 0", bus.in_ready);
        end
        tick();
        bus.write = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL raw_release: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00104, rs1: mregs[6], rs2: mregs[6], rd: 5'd7, rdw: 1'b1,
                       imm: 32'h0});
        tick();
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_PC !== e.pc || bus.rs1_data !== e.rs1 ||
            bus.rs2_data !== e.rs2 || bus.rd !== e.rd) begin
            miscompares++;
            $display("FAIL raw_entry: got v=%b pc=%h rs1=%h rs2=%h rd=%0d want v=1 pc=%h rs1=%h rs2=%h rd=%0d",
                     bus.out_valid, bus.out_PC, bus.rs1_data, bus.rs2_data, bus.rd,
                     e.pc, e.rs1, e.rs2, e.rd);
        end
        tick();
        writeback(5'd7, 32'h77);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        offer(20'h00200, enc_i(OpImm, 5'd8, 3'd0, 5'd0, 12'd5));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_accept_a: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00200, rs1: 32'h0, rs2: 32'h0, rd: 5'd8, rdw: 1'b1, imm: 32'd5});
        tick();
        offer(20'h00204, enc_i(OpImm, 5'd10, 3'd6, 5'd0, 12'd3));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_PC !== 20'h00200 ||
                bus.extend_imm !== 32'd5 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b pc=%h imm=%h rdy=%b want v=1 pc=00200 imm=5 rdy=0",
                         i, bus.out_valid, bus.out_PC, bus.extend_imm, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.rd !== e.rd || bus.rs1_data !== e.rs1) begin
            miscompares++;
            $display("FAIL bp_release: got rdy=%b rd=%0d rs1=%h want rdy=1 rd=%0d rs1=%h",
                     bus.in_ready, bus.rd, bus.rs1_data, e.rd, e.rs1);
        end
        sb.push_back('{pc: 20'h00204, rs1: 32'h0, rs2: 32'h0, rd: 5'd10, rdw: 1'b1, imm: 32'd3});
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_PC !== e.pc || bus.extend_imm !== e.imm ||
            bus.funct3 !== 3'd6 || bus.rd !== e.rd) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b pc=%h imm=%h f3=%0d rd=%0d want v=1 pc=%h imm=%h f3=6 rd=%0d",
                     bus.out_valid, bus.out_PC, bus.extend_imm, bus.funct3, bus.rd,
                     e.pc, e.imm, e.rd);
        end
        tick();
        writeback(5'd8, 32'd5);
        writeback(5'd10, 32'd3);
    endtask

    task automatic test_branch_wrap();
        offer(20'h00010, enc_b(13'h1FE0, 5'd0, 5'd0));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL beq_accept: in_ready got %b want 1", bus.in_ready);
        end
        tick();
        // Next instruction reads x1, which the BEQ's rd field aliases but must not mark busy.
        offer(20'h00014, enc_i(OpImm, 5'd11, 3'd0, 5'd1, 12'd0));
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.branch_target !== 20'hFFFF0 ||
            bus.rd_write !== 1'b0 || bus.extend_imm !== 32'hFFFF_FFE0) begin
            miscompares++;
            $display("FAIL beq_entry: got v=%b bt=%h rdw=%b imm=%h want v=1 bt=ffff0 rdw=0 imm=ffffffe0",
                     bus.out_valid, bus.branch_target, bus.rd_write, bus.extend_imm);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL beq_no_busy: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00014, rs1: mregs[1], rs2: 32'h0, rd: 5'd11, rdw: 1'b1,
                       imm: 32'h0});
        tick();
        offer(20'hFFFF8, enc_j(21'd16, 5'd1));
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_PC !== e.pc || bus.rs1_data !== e.rs1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_accept: got pc=%h rs1=%h rdy=%b want pc=%h rs1=%h rdy=1",
                     bus.out_PC, bus.rs1_data, bus.in_ready, e.pc, e.rs1);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.JAL_target !== 20'h00008 ||
            bus.extend_imm !== 32'd16 || bus.rd_write !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_entry: got v=%b jt=%h imm=%h rdw=%b want v=1 jt=00008 imm=10 rdw=1",
                     bus.out_valid, bus.JAL_target, bus.extend_imm, bus.rd_write);
        end
        tick();
        offer(20'h00018, enc_i(OpImm, 5'd14, 3'd0, 5'd1, 12'd0));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL jal_busy: in_ready got %b want 0", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        writeback(5'd1, 32'h11);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        offer(20'h00300, enc_i(OpLoad, 5'd9, 3'd2, 5'd2, 12'd0));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL lw_accept: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00300, rs1: mregs[2], rs2: 32'h0, rd: 5'd9, rdw: 1'b1,
                       imm: 32'h0});
        tick();
        bus.in_valid = 1'b0;
        bus.instruction = 32'h0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: got v=%b rdy=%b want v=1 rdy=0", bus.out_valid,
                     bus.in_ready);
        end
        tick();
        bus.flush = 1'b0;
        void'(sb.pop_front());
        offer(20'h00304, enc_i(OpImm, 5'd12, 3'd0, 5'd9, 12'd0));
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_after: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid,
                     bus.in_ready);
        end
        sb.push_back('{pc: 20'h00304, rs1: mregs[9], rs2: 32'h0, rd: 5'd12, rdw: 1'b1,
                       imm: 32'h0});
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_PC !== e.pc || bus.rs1_data !== e.rs1 ||
            bus.rd !== e.rd) begin
            miscompares++;
            $display("FAIL flush_reader: got v=%b pc=%h rs1=%h rd=%0d want v=1 pc=%h rs1=%h rd=%0d",
                     bus.out_valid, bus.out_PC, bus.rs1_data, bus.rd, e.pc, e.rs1, e.rd);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        offer(20'h00400, enc_i(OpImm, 5'd13, 3'd0, 5'd0, 12'd7));
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_async: out_valid got %b want 0", bus.out_valid);
        end
        sb.delete();
        foreach (mregs[i]) mregs[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        offer(20'h00404, enc_i(OpImm, 5'd13, 3'd0, 5'd5, 12'd0));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_ready: in_ready got %b want 1", bus.in_ready);
        end
        sb.push_back('{pc: 20'h00404, rs1: mregs[5], rs2: 32'h0, rd: 5'd13, rdw: 1'b1,
                       imm: 32'h0});
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_PC !== e.pc || bus.rs1_data !== e.rs1) begin
            miscompares++;
            $display("FAIL midrst_x5: got v=%b pc=%h rs1=%h want v=1 pc=%h rs1=%h",
                     bus.out_valid, bus.out_PC, bus.rs1_data, e.pc, e.rs1);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.PC = '0; bus.instruction = '0;
        bus.write = 1'b0; bus.write_reg = '0; bus.write_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        foreach (mregs[i]) mregs[i] = 32'h0;
        test_reset();
        test_addi();
        test_raw_hazard();
        test_backpressure();
        test_branch_wrap();
        test_flush();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
